// File: rtl/uart_wb_bridge.sv
// UART byte-stream to Wishbone classic master bridge.
// Frames: 'W' addr[4] data[4] -> status; 'R' addr[4] -> status [+ data[4]].
module uart_wb_bridge #(
    parameter int WISHBONE_ADDR_WIDTH = 32,
    parameter int WISHBONE_BUS_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES      = 255
) (
    input  logic                           CLK_I,
    input  logic                           RST_NI,
    input  logic [7:0]                     RX_DATA_I,
    input  logic                           RX_VALID_I,
    output logic [7:0]                     TX_DATA_O,
    output logic                           TX_VALID_O,
    input  logic                           TX_READY_I,
    output logic [WISHBONE_ADDR_WIDTH-1:0] WBM_ADR_O,
    output logic [WISHBONE_BUS_WIDTH-1:0]  WBM_DAT_O,
    input  logic [WISHBONE_BUS_WIDTH-1:0]  WBM_DAT_I,
    output logic                           WBM_WE_O,
    output logic [3:0]                     WBM_SEL_O,
    output logic                           WBM_CYC_O,
    output logic                           WBM_STB_O,
    input  logic                           WBM_ACK_I,
    input  logic                           WBM_ERR_I,
    output logic                           BUSY_O
);

    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CH_W = 8'h57;
    localparam logic [7:0] CH_R = 8'h52;
    localparam logic [7:0] CH_Q = 8'h3F;
    localparam logic [7:0] CH_K = 8'h4B;
    localparam logic [7:0] CH_E = 8'h45;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_ADDR,
        S_RX_DATA,
        S_BUS,
        S_TX_STATUS,
        S_TX_RDATA
    } state_t;

    state_t                        state_q, state_d;
    logic                          we_q, we_d;
    logic [1:0]                    cnt_q, cnt_d;
    logic [31:0]                   addr_q, addr_d;
    logic [WISHBONE_BUS_WIDTH-1:0] wdata_q, wdata_d;
    logic [WISHBONE_BUS_WIDTH-1:0] rdata_q, rdata_d;
    logic [7:0]                    status_q, status_d;
    logic [TOW-1:0]                to_q, to_d;

    always_ff @(posedge CLK_I) begin
        if (!RST_NI) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            status_q <= '0;
            to_q     <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            status_q <= status_d;
            to_q     <= to_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        status_d = status_q;
        to_d     = to_q;
        unique case (state_q)
            S_IDLE: begin
                if (RX_VALID_I) begin
                    cnt_d = '0;
                    if (RX_DATA_I == CH_W) begin
                        we_d    = 1'b1;
                        state_d = S_RX_ADDR;
                    end else if (RX_DATA_I == CH_R) begin
                        we_d    = 1'b0;
                        state_d = S_RX_ADDR;
                    end else begin
                        status_d = CH_Q;
                        state_d  = S_TX_STATUS;
                    end
                end
            end
            S_RX_ADDR: begin
                if (RX_VALID_I) begin
                    addr_d = {addr_q[23:0], RX_DATA_I};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = we_q ? S_RX_DATA : S_BUS;
                    end
                end
            end
            S_RX_DATA: begin
                if (RX_VALID_I) begin
                    wdata_d = {wdata_q[23:0], RX_DATA_I};
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_BUS;
                    end
                end
            end
            S_BUS: begin
                // Termination wins over a timeout landing in the same cycle.
                if (WBM_ACK_I || WBM_ERR_I) begin
                    status_d = (WBM_ACK_I && !WBM_ERR_I) ? CH_K : CH_E;
                    if (WBM_ACK_I && !we_q) begin
                        rdata_d = WBM_DAT_I;
                    end
                    to_d    = '0;
                    state_d = S_TX_STATUS;
                end else if (to_q == TO_LAST) begin
                    status_d = CH_E;
                    to_d     = '0;
                    state_d  = S_TX_STATUS;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_TX_STATUS: begin
                if (TX_READY_I) begin
                    cnt_d = '0;
                    if (!we_q && status_q == CH_K) begin
                        state_d = S_TX_RDATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_TX_RDATA: begin
                if (TX_READY_I) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        TX_VALID_O = 1'b0;
        TX_DATA_O  = 8'h00;
        WBM_CYC_O  = 1'b0;
        WBM_STB_O  = 1'b0;
        WBM_WE_O   = 1'b0;
        WBM_SEL_O  = 4'h0;
        BUSY_O     = (state_q != S_IDLE);
        unique case (state_q)
            S_BUS: begin
                WBM_CYC_O = 1'b1;
                WBM_STB_O = 1'b1;
                WBM_WE_O  = we_q;
                WBM_SEL_O = 4'hF;
            end
            S_TX_STATUS: begin
                TX_VALID_O = 1'b1;
                TX_DATA_O  = status_q;
            end
            S_TX_RDATA: begin
                TX_VALID_O = 1'b1;
                unique case (cnt_q)
                    2'd0:    TX_DATA_O = rdata_q[31:24];
                    2'd1:    TX_DATA_O = rdata_q[23:16];
                    2'd2:    TX_DATA_O = rdata_q[15:8];
                    default: TX_DATA_O = rdata_q[7:0];
                endcase
            end
            default: ;
        endcase
    end

    assign WBM_DAT_O = wdata_q;

    if (WISHBONE_ADDR_WIDTH <= 32) begin : g_adr_narrow
        assign WBM_ADR_O = addr_q[WISHBONE_ADDR_WIDTH-1:0];
    end else begin : g_adr_wide
        assign WBM_ADR_O = {{(WISHBONE_ADDR_WIDTH-32){1'b0}}, addr_q};
    end

endmodule
